// File: rtl/var_slice_packer_if.sv
// Beat/word handshake bundle for var_slice_packer: field beats in, assembled words out.
// master = producer/consumer side, slave = the packer.
interface var_slice_packer_if #(
  parameter int WW = 32,
  parameter int FW = 4,
  parameter int PW = 5
);
  logic [FW-1:0] IN_DATA;
  logic [PW-1:0] IN_POS;
  logic          IN_LAST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [WW-1:0] OUT_WORD;
  logic [WW-1:0] OUT_MASK;
  logic          OUT_VALID;
  logic          OUT_READY;

  modport master (
    output IN_DATA, IN_POS, IN_LAST, IN_VALID, OUT_READY,
    input  IN_READY, OUT_WORD, OUT_MASK, OUT_VALID
  );

  modport slave (
    input  IN_DATA, IN_POS, IN_LAST, IN_VALID, OUT_READY,
    output IN_READY, OUT_WORD, OUT_MASK, OUT_VALID
  );
endinterface

// File: rtl/var_slice_packer.sv
// Inserts FW-bit fields at a runtime bit position into a WW-bit word; one-entry output buffer.
// Optional sticky overlap flag when VAR_SLICE_OVERLAP_ERR_EN is defined; otherwise ERR is tied 0.
module var_slice_packer #(
  parameter int WW = 32,
  parameter int FW = 4,
  parameter int PW = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  var_slice_packer_if.slave    bus,
  output logic                 ERR
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_acc;
  logic [WW-1:0] r_acc_mask;
  logic [WW-1:0] r_out_word;
  logic [WW-1:0] r_out_mask;
  logic [WW-1:0] w_fdata;
  logic [WW-1:0] w_fmask;
  logic [WW-1:0] w_acc_nxt;
  logic [WW-1:0] w_mask_nxt;
  logic [PW:0]   w_idx;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_accept_last;

  assign w_in_ready    = (r_state == FILL) || bus.OUT_READY;
  assign w_accept      = bus.IN_VALID && w_in_ready;
  assign w_accept_last = w_accept && bus.IN_LAST;

  // Index kept one bit wider than PW so positions past WW-1 are dropped, never wrapped
  always_comb begin
    w_fdata = '0;
    w_fmask = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < FW; i++) begin
      w_idx = {1'b0, bus.IN_POS} + (PW+1)'(i);
      if (w_idx < (PW+1)'(WW)) begin
        w_fmask[w_idx[PW-1:0]] = 1'b1;
        w_fdata[w_idx[PW-1:0]] = bus.IN_DATA[i];
      end
    end
  end

  assign w_acc_nxt  = (r_acc & ~w_fmask) | w_fdata;
  assign w_mask_nxt = r_acc_mask | w_fmask;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: if (w_accept_last) w_state_nxt = HOLD;
      HOLD: if (bus.OUT_READY && !w_accept_last) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc      <= '0;
      r_acc_mask <= '0;
      r_out_word <= '0;
      r_out_mask <= '0;
    end else if (w_accept) begin
      if (bus.IN_LAST) begin
        r_out_word <= w_acc_nxt;
        r_out_mask <= w_mask_nxt;
        r_acc      <= '0;
        r_acc_mask <= '0;
      end else begin
        r_acc      <= w_acc_nxt;
        r_acc_mask <= w_mask_nxt;
      end
    end
  end

`ifdef VAR_SLICE_OVERLAP_ERR_EN
  logic r_err;
  always_ff @(posedge CLK) begin
    if (RST)                                 r_err <= 1'b0;
    else if (w_accept && |(w_fmask & r_acc_mask)) r_err <= 1'b1;
  end
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_WORD  = r_out_word;
  assign bus.OUT_MASK  = r_out_mask;
  assign bus.OUT_VALID = (r_state == HOLD);

endmodule
